cfg_chain_loader: RTL and testbench

- Programming-chain controller for a row of configurable cells.
- Accepts the configuration bitstream as 32-bit words over a valid/ready stream.
- Serializes the words onto the row's daisy-chained programming input, generating the programming enable.
- Signals completion; optionally verifies the loaded chain by non-destructive recirculation and CRC compare.

---
 rtl/cfg_chain_loader_pkg.sv | 10 +
 rtl/cfg_chain_loader_crc16_serial.sv | 25 ++
 rtl/cfg_chain_loader.sv | 173 +++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and constants for the configuration-chain loader and its CRC helper.
package cfg_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, VERIFY, DONE} state_t;

   localparam logic [15:0] CRC16_POLY     = 16'h1021;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam int unsigned WORD_W_DEFAULT = 32;

endpackage

// File: rtl/cfg_chain_loader_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clr reloads the init value.
module crc16_serial
   import cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic fb;

   always_comb fb = crc[15] ^ din;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc <= CRC16_INIT;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
      end
   end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serializes 32-bit configuration words onto a daisy-chained cell row.
// Optional readback verify via recirculation: define CFG_CHAIN_READBACK_EN.
module cfg_chain_loader
   import cfg_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 224,
   parameter int unsigned WORD_W    = WORD_W_DEFAULT,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              chain_out,
   output logic              chain_en,
   input  logic              chain_in,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  bits_left
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            state, state_d;
   logic [WORD_W-1:0] shreg, shreg_d;
   logic [CNT_W-1:0]  bits_d, wcnt, wcnt_d, refill_src, take;
   logic              crc_clr, crc_wr_en;
   logic [15:0]       crc_wr;

`ifdef CFG_CHAIN_READBACK_EN
   logic [CNT_W-1:0] vcnt, vcnt_d;
   logic             crc_rd_en, err_q, err_d;
   logic [15:0]      crc_rd;

   crc16_serial u_crc_rd (
      .clk (prog_clk),
      .rst (prog_rst),
      .clr (crc_clr),
      .en  (crc_rd_en),
      .din (chain_in),
      .crc (crc_rd)
   );

   // The mismatch is visible during the done pulse itself, then held in err_q.
   assign error = err_q | ((state == DONE) && (crc_rd != crc_wr));
`else
   logic unused_ok;
   assign unused_ok = ^{chain_in, crc_wr};
   assign error     = 1'b0;
`endif

   crc16_serial u_crc_wr (
      .clk (prog_clk),
      .rst (prog_rst),
      .clr (crc_clr),
      .en  (crc_wr_en),
      .din (chain_out),
      .crc (crc_wr)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      state_d    = state;
      shreg_d    = shreg;
      bits_d     = bits_left;
      wcnt_d     = wcnt;
      word_ready = 1'b0;
      chain_en   = 1'b0;
      chain_out  = 1'b0;
      crc_clr    = 1'b0;
      crc_wr_en  = 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
      vcnt_d     = vcnt;
      crc_rd_en  = 1'b0;
      err_d      = err_q;
`endif
      // Word bit count = min(WORD_W, bits still owed when the word lands).
      refill_src = (state == LOAD) ? bits_left : bits_left - ONE;
      take       = (32'(refill_src) >= WORD_W) ? CNT_W'(WORD_W) : refill_src;

      case (state)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               bits_d  = CNT_W'(CHAIN_LEN);
               crc_clr = 1'b1;
`ifdef CFG_CHAIN_READBACK_EN
               err_d   = 1'b0;
`endif
            end
         end
         LOAD: begin
            word_ready = 1'b1;
            if (word_valid) begin
               shreg_d = word_data;
               wcnt_d  = take;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            chain_en  = 1'b1;
            chain_out = shreg[0];
            crc_wr_en = 1'b1;
            shreg_d   = shreg >> 1;
            bits_d    = bits_left - ONE;
            wcnt_d    = wcnt - ONE;
            if (bits_left == ONE) begin
`ifdef CFG_CHAIN_READBACK_EN
               state_d = VERIFY;
               vcnt_d  = CNT_W'(CHAIN_LEN);
`else
               state_d = DONE;
`endif
            end else if (wcnt == ONE) begin
               word_ready = 1'b1;
               if (word_valid) begin
                  shreg_d = word_data;
                  wcnt_d  = take;
               end else begin
                  state_d = LOAD;
               end
            end
         end
`ifdef CFG_CHAIN_READBACK_EN
         VERIFY: begin
            chain_en  = 1'b1;
            chain_out = chain_in;
            crc_rd_en = 1'b1;
            vcnt_d    = vcnt - ONE;
            if (vcnt == ONE) state_d = DONE;
         end
`endif
         DONE: begin
            state_d = IDLE;
`ifdef CFG_CHAIN_READBACK_EN
            err_d   = error;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Reset must stop the row shifting in the very cycle it is asserted.
      if (prog_rst) chain_en = 1'b0;
   end

   always_ff @(posedge prog_clk) begin
      if (prog_rst) begin
         state     <= IDLE;
         shreg     <= '0;
         bits_left <= '0;
         wcnt      <= '0;
`ifdef CFG_CHAIN_READBACK_EN
         vcnt      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         shreg     <= shreg_d;
         bits_left <= bits_d;
         wcnt      <= wcnt_d;
`ifdef CFG_CHAIN_READBACK_EN
         vcnt      <= vcnt_d;
         err_q     <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomized self-checking bench for cfg_chain_loader against a bit-level chain model.
`timescale 1ns/1ps
module tb_cfg_chain_loader;

   localparam int unsigned N  = 40;
   localparam int unsigned N2 = 32;
   localparam int unsigned W  = 32;
`ifdef CFG_CHAIN_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam logic [N-1:0] FLIP_MASK = 40'd32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, valid, chain_in, ready, cout, cen, busy, done, error;
   logic [W-1:0] data;
   logic [5:0]   bl;
   logic         start2, valid2, ready2, cout2, cen2, busy2, done2, error2;
   logic [W-1:0] data2;
   logic [5:0]   bl2;
   logic         chain_in2 = 1'b0;
   logic         flip = 1'b0;
   logic [N-1:0] chain = '0;
   int           tests = 0;
   int           fails = 0;

   cfg_chain_loader #(.CHAIN_LEN(N)) dut (
      .prog_clk(clk), .prog_rst(rst), .start(start), .word_data(data),
      .word_valid(valid), .word_ready(ready), .chain_out(cout), .chain_en(cen),
      .chain_in(chain_in), .busy(busy), .done(done), .error(error), .bits_left(bl)
   );

   cfg_chain_loader #(.CHAIN_LEN(N2)) dut32 (
      .prog_clk(clk), .prog_rst(rst), .start(start2), .word_data(data2),
      .word_valid(valid2), .word_ready(ready2), .chain_out(cout2), .chain_en(cen2),
      .chain_in(chain_in2), .busy(busy2), .done(done2), .error(error2), .bits_left(bl2)
   );

   // Row model: prog_in enters at bit 0, the tail (prog_out) is bit N-1.
   assign chain_in = chain[N-1];
   always @(posedge clk)
      chain <= (cen ? {chain[N-2:0], cout} : chain) ^ (flip ? FLIP_MASK : '0);

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic run_load(input bit fixed, input int gap, input int rst_at,
                           input bit corrupt, input bit poke);
      logic [W-1:0] words [2];
      logic [N-1:0] exp_chain;
      bit           exp_bits [N];
      int nacc = 0, nshift = 0, nver = 0, run = 0, maxrun = 0;
      int wait_n = 0, stall = 0, last_en = -10, cyc = 0;
      bit got_done = 1'b0;
      if (fixed) begin
         words[0] = 32'hA5A5_A5A5;
         words[1] = 32'h0000_00C3;
      end else begin
         words[0] = $urandom;
         words[1] = $urandom;
      end
      for (int i = 0; i < N; i++) exp_bits[i] = words[i/W][i%W];
      for (int i = 0; i < N; i++) exp_chain[N-1-i] = exp_bits[i];
      if (corrupt) exp_chain = exp_chain ^ FLIP_MASK;

      @(negedge clk); start = 1'b1; valid = 1'b0;
      @(negedge clk); start = 1'b0;
      check("busy_start", busy, 1);
      check("bl_start", bl, N);
      check("err_cleared", error, 0);

      while (!got_done && cyc < 400) begin
         flip = 1'b0;
         if (rst_at >= 0 && cen && nshift == rst_at) begin
            rst = 1'b1; valid = 1'b0;
            #1 check("rst_en_now", cen, 0);
            @(negedge clk);
            check("rst_en", cen, 0);
            check("rst_busy", busy, 0);
            check("rst_bl", bl, 0);
            check("rst_done", done, 0);
            rst = 1'b0;
            return;
         end
         check("busy", busy, 1);
         if (cen) begin
            if (nshift < N) begin
               check("bit", cout, exp_bits[nshift]);
               check("bl_shift", bl, N - nshift);
               nshift++;
               if (nshift == N && corrupt) flip = 1'b1;
            end else begin
               check("recirc", cout, chain_in);
               check("bl_verify", bl, 0);
               nver++;
            end
            run++;
            if (run > maxrun) maxrun = run;
            last_en = cyc;
         end else begin
            run = 0;
            if (nshift > 0 && nshift < N) stall++;
            check("bl_hold", bl, N - nshift);
         end
         if (nacc == 2) check("no_surplus", ready, 0);
         if (done) begin
            got_done = 1'b1;
            check("done_lat", cyc - last_en, 1);
            check("nshift", nshift, N);
            check("nver", nver, RB ? N : 0);
            check("stall", stall, gap);
            check("nacc", nacc, 2);
            check("error_done", error, RB && corrupt);
            check("chain", chain, exp_chain);
            if (gap == 0) check("en_run", maxrun, RB ? 2*N : N);
         end
         start = (poke && cen && nshift == 10);
         if (ready && wait_n > 0) begin
            valid = 1'b0;
            wait_n--;
         end else if (nacc < 2) begin
            valid = 1'b1;
            data  = words[nacc];
         end else begin
            valid = 1'b0;
         end
         if (valid && ready) begin
            nacc++;
            if (nacc == 1) wait_n = gap;
         end
         @(negedge clk);
         cyc++;
      end
      valid = 1'b0; start = 1'b0;
      if (!got_done) check("timeout", 0, 1);
      for (int k = 0; k < 2; k++) begin
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("sticky_err", error, RB && corrupt);
         check("idle_ready", ready, 0);
         @(negedge clk);
      end
   endtask

   task automatic run32();
      int en_n = 0, rdy_after = 0, cyc = 0;
      bit gd = 1'b0, acc = 1'b0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      check("bl32_start", bl2, N2);
      valid2 = 1'b1; data2 = '1;
      while (!gd && cyc < 200) begin
         if (acc && ready2) rdy_after++;
         if (cen2) begin
            if (en_n < N2) check("bit32", cout2, 1);
            en_n++;
         end
         if (done2) begin
            gd = 1'b1;
            check("bl32_end", bl2, 0);
         end
         if (valid2 && ready2) acc = 1'b1;
         @(negedge clk);
         cyc++;
      end
      valid2 = 1'b0;
      check("done32", gd, 1);
      check("en32", en_n, RB ? 2*N2 : N2);
      check("rdy32", rdy_after, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
      start2 = 1'b0; valid2 = 1'b0; data2 = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_cen", cen, 0);
      check("rst_cout", cout, 0);
      check("rst_busy0", busy, 0);
      check("rst_done0", done, 0);
      check("rst_error", error, 0);
      check("rst_bl0", bl, 0);
      rst = 1'b0;

      valid = 1'b1; data = $urandom;
      repeat (4) begin
         @(negedge clk);
         check("idle_valid_rdy", ready, 0);
         check("idle_valid_busy", busy, 0);
      end
      valid = 1'b0;

      run_load(1'b1, 0, -1, 1'b0, 1'b0);
      run_load(1'b1, 5, -1, 1'b0, 1'b0);
      run_load(1'b1, 0, 17, 1'b0, 1'b0);
      run_load(1'b1, 0, -1, 1'b0, 1'b1);
      run_load(1'b0, 2, -1, 1'b1, 1'b0);
      for (int t = 0; t < 8; t++)
         run_load(1'b0, int'($urandom_range(0, 4)), -1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run32();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
